// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: the per-cycle action
// chosen by the priority encoder and the skip stride.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_SKIP,
    PC_JUMP,
    PC_CALL,
    PC_RET,
    PC_HALT
  } pc_action_t;

  localparam int SKIP_STRIDE = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit to sequencer bundle. The control unit is the master and
// drives the strobes. The sequencer is the slave and returns pc and status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              en;
  logic              halt;
  logic              skip;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  modport master (
    output en, halt, skip, jump, call, ret, jump_addr,
    input  pc, halted, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  en, halt, skip, jump, call, ret, jump_addr,
    output pc, halted, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO of return addresses. A push is ignored when the stack is full and a
// pop is ignored when it is empty; the caller decides what counts as an error.
module ret_stack #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(STACK_DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Reading the slot below count while empty is harmless: top_o is only
  // consumed when a pop is actually accepted.
  assign wr_idx = IDX_W'(count_q);
  assign rd_idx = IDX_W'(count_q - CNT_W'(1));
  assign top_o  = mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (do_push)     count_d = count_q + CNT_W'(1);
    else if (do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_data_i;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter. It picks one action per enabled cycle:
// increment, skip, jump, call, return or halt. It owns the return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = 5,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  pc_action_t        action;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty, stk_full;

  always_comb begin
    action = PC_HOLD;
    if (bus.en && !halted_q) begin
      if      (bus.halt) action = PC_HALT;
      else if (bus.ret)  action = PC_RET;
      else if (bus.call) action = PC_CALL;
      else if (bus.jump) action = PC_JUMP;
      else if (bus.skip) action = PC_SKIP;
      else               action = PC_INC;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    case (action)
      PC_HALT: halted_d = 1'b1;
      PC_RET: begin
        if (stk_empty) err_d = 1'b1;
        else begin
          pc_d = stk_top;
          pop  = 1'b1;
        end
      end
      PC_CALL: begin
        if (stk_full) err_d = 1'b1;
        else begin
          pc_d = bus.jump_addr;
          push = 1'b1;
        end
      end
      PC_JUMP: pc_d = bus.jump_addr;
      PC_SKIP: pc_d = pc_q + ADDR_W'(SKIP_STRIDE);
      PC_INC:  pc_d = pc_q + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_ADDR;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  ret_stack #(
    .ADDR_W     (ADDR_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(pc_q + ADDR_W'(1)),
    .top_o      (stk_top),
    .empty_o    (stk_empty),
    .full_o     (stk_full)
  );

  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_full  = stk_full;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, a mid-cycle
// reset check, then random traffic against a queue-based reference model.
module tb_pc_sequencer;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int MODW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(5'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    bit       en, halt, skip, jump, call, ret;
    int       ja;
    int       e_pc;
    bit       e_halted, e_empty, e_full, e_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int   m_pc;
  bit   m_halted, m_err;
  int   m_stack[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int pc, input bit h,
                           input bit e, input bit f, input bit er);
    check({tag, ".pc"},     int'(bus.pc),          pc);
    check({tag, ".halted"}, int'(bus.halted),      int'(h));
    check({tag, ".empty"},  int'(bus.stack_empty), int'(e));
    check({tag, ".full"},   int'(bus.stack_full),  int'(f));
    check({tag, ".err"},    int'(bus.stack_err),   int'(er));
  endtask

  function automatic void add(bit en, bit halt, bit skip, bit jump, bit call,
                              bit ret, int ja, int pc, bit h, bit e, bit f,
                              bit er);
    vec_t v;
    v.en = en; v.halt = halt; v.skip = skip; v.jump = jump; v.call = call;
    v.ret = ret; v.ja = ja; v.e_pc = pc; v.e_halted = h; v.e_empty = e;
    v.e_full = f; v.e_err = er;
    vecs.push_back(v);
  endfunction

  task automatic drive(input bit en, input bit halt, input bit skip,
                       input bit jump, input bit call, input bit ret,
                       input int ja);
    bus.en = en; bus.halt = halt; bus.skip = skip; bus.jump = jump;
    bus.call = call; bus.ret = ret; bus.jump_addr = ADDR_W'(ja);
  endtask

  task automatic model_reset();
    m_pc = 0; m_halted = 0; m_err = 0;
    m_stack.delete();
  endtask

  function automatic void model_step(bit en, bit halt, bit skip, bit jump,
                                     bit call, bit ret, int ja);
    if (!en || m_halted) return;
    if (halt) m_halted = 1;
    else if (ret) begin
      if (m_stack.size() == 0) m_err = 1;
      else m_pc = m_stack.pop_back();
    end else if (call) begin
      if (m_stack.size() == DEPTH) m_err = 1;
      else begin
        m_stack.push_back((m_pc + 1) % MODW);
        m_pc = ja;
      end
    end else if (jump) m_pc = ja;
    else if (skip) m_pc = (m_pc + 2) % MODW;
    else m_pc = (m_pc + 1) % MODW;
  endfunction

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(tag, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vecs[i].en, vecs[i].halt, vecs[i].skip, vecs[i].jump,
            vecs[i].call, vecs[i].ret, vecs[i].ja);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_halted,
                vecs[i].e_empty, vecs[i].e_full, vecs[i].e_err);
    end
  endtask

  int split;

  initial begin
    // en halt skip jump call ret ja | pc halted empty full err
    add(1,0,0,0,0,0, 0,   1, 0,1,0,0);
    add(1,0,0,0,0,0, 0,   2, 0,1,0,0);
    add(1,0,0,0,0,0, 0,   3, 0,1,0,0);
    split = vecs.size();
    add(1,0,0,1,0,0, 30, 30, 0,1,0,0);
    add(1,0,1,0,0,0, 0,   0, 0,1,0,0);
    add(1,0,1,0,0,0, 0,   2, 0,1,0,0);
    add(1,0,0,1,0,0, 31, 31, 0,1,0,0);
    add(1,0,1,0,0,0, 0,   1, 0,1,0,0);
    add(1,0,0,1,0,0, 31, 31, 0,1,0,0);
    add(1,0,0,0,0,0, 0,   0, 0,1,0,0);
    add(1,0,0,1,0,0, 3,   3, 0,1,0,0);
    add(1,0,0,0,1,0, 20, 20, 0,0,0,0);
    add(1,0,0,0,1,0, 9,   9, 0,0,0,0);
    add(1,0,0,0,0,1, 0,  21, 0,0,0,0);
    add(1,0,0,0,0,1, 0,   4, 0,1,0,0);
    add(1,0,0,0,1,0, 10, 10, 0,0,0,0);
    add(1,0,0,0,1,0, 11, 11, 0,0,0,0);
    add(1,0,0,0,1,0, 12, 12, 0,0,0,0);
    add(1,0,0,0,1,0, 13, 13, 0,0,1,0);
    add(1,0,0,0,1,0, 7,  13, 0,0,1,1);
    add(1,0,0,0,0,1, 0,  13, 0,0,0,1);
    add(1,0,0,0,0,1, 0,  12, 0,0,0,1);
    add(1,0,0,0,0,1, 0,  11, 0,0,0,1);
    add(1,0,0,0,0,1, 0,   5, 0,1,0,1);
    add(1,0,0,0,0,1, 0,   5, 0,1,0,1);
    add(1,0,1,1,1,0, 12, 12, 0,0,0,1);
    add(1,0,0,1,0,1, 20,  6, 0,1,0,1);
    add(0,0,0,1,0,0, 17,  6, 0,1,0,1);
    add(0,1,0,0,0,0, 0,   6, 0,1,0,1);
    add(1,1,1,1,1,1, 9,   6, 1,1,0,1);
    add(1,0,0,1,0,0, 1,   6, 1,1,0,1);
    add(1,0,0,0,0,1, 0,   6, 1,1,0,1);
    add(0,0,0,0,0,0, 0,   6, 1,1,0,1);
    add(1,0,0,0,1,0, 22,  6, 1,1,0,1);

    model_reset();
    do_reset("rst0");
    run_vecs(0, split);

    // Asynchronous reset between clock edges must clear pc immediately.
    drive(1, 0, 0, 1, 0, 0, 19);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.pc", int'(bus.pc), 0);
    check("async_rst.empty", int'(bus.stack_empty), 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_reset("rst1");
    run_vecs(split, vecs.size());
    do_reset("rst2");

    for (int n = 0; n < 1500; n++) begin
      bit en, halt, skip, jump, call, ret;
      int ja;
      if ($urandom_range(0, 119) == 0) begin
        do_reset("rst_rand");
        continue;
      end
      en   = ($urandom_range(0, 9) != 0);
      halt = ($urandom_range(0, 149) == 0);
      skip = ($urandom_range(0, 3) == 0);
      jump = ($urandom_range(0, 3) == 0);
      call = ($urandom_range(0, 3) == 0);
      ret  = ($urandom_range(0, 3) == 0);
      ja   = int'($urandom_range(0, MODW - 1));
      drive(en, halt, skip, jump, call, ret, ja);
      @(posedge clk);
      model_step(en, halt, skip, jump, call, ret, ja);
      #1;
      check_all("rand", m_pc, m_halted, m_stack.size() == 0,
                m_stack.size() == DEPTH, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
